ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: instruction-memory read data valid.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-008 The block SHALL have port ir, output, 32 bits: fetched instruction, fed to the field decoder.
REQ-009 The block SHALL have port pc, output, 32 bits: address of the instruction held in ir.
REQ-010 The block SHALL have port ir_valid, output, 1 bit: ir/pc hold a valid instruction.
REQ-011 The block SHALL have port ir_take, input, 1 bit: downstream consumes ir this cycle.
REQ-012 The block SHALL have port jmp, input, 1 bit: taken J-type redirect for the instruction in ir.
REQ-013 The block SHALL have port jmp_ind, input, 26 bits: J-type index field.
REQ-014 The block SHALL have port br_taken, input, 1 bit: taken branch redirect for the instruction in ir.
REQ-015 The block SHALL have port br_imm, input, 16 bits: branch offset, signed, in words.

Function
REQ-016 The FSM SHALL have states REQ (request outstanding) and HOLD (instruction presented).
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the internal fetch_pc, both stable until imem_ack.
REQ-018 On imem_ack in REQ, the block SHALL capture ir<=imem_rdata, pc<=fetch_pc, set ir_valid=1, and enter HOLD at the next edge (ack in cycle N -> ir_valid in N+1).
REQ-019 In HOLD, imem_req SHALL be 0, and ir, pc and ir_valid SHALL hold until ir_take=1.
REQ-020 On ir_take in HOLD, the block SHALL clear ir_valid, load fetch_pc with the next-PC, and enter REQ.
REQ-021 The next-PC SHALL be {pc[31:28], jmp_ind, 2'b00} if jmp=1.
REQ-022 Else, the next-PC SHALL be pc+4+(sign_ext(br_imm)<<2) if br_taken=1.
REQ-023 Else, the next-PC SHALL be pc+4.
REQ-024 jmp SHALL take priority over br_taken when both are 1.
REQ-025 jmp, br_taken, jmp_ind and br_imm SHALL be ignored unless ir_take=1 in HOLD.
REQ-026 ir_take in REQ SHALL be ignored.
REQ-027 imem_ack in HOLD SHALL be ignored.
REQ-028 All PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 -> 32'h0000_0000; branch wrap likewise.
REQ-029 imem_addr[1:0] SHALL always be 2'b00; the 2 LSBs of any computed target SHALL be forced to 0.
REQ-030 Two consecutive instructions SHALL take at least 2 cycles (HOLD then REQ); no prefetch.

Reset
REQ-031 While rst=1 at a clock edge, state SHALL become REQ, fetch_pc=RESET_PC, ir=0, pc=0, ir_valid=0.
REQ-032 While rst=1, imem_req SHALL be 0.
REQ-033 Reset SHALL have priority over imem_ack and ir_take in the same cycle.
REQ-034 On reset mid-request, the request SHALL be abandoned and re-issued from RESET_PC in the first cycle after rst falls.

Structure
REQ-035 A shared package SHALL hold the RESET_PC default, the state encoding and the PC-increment constant (4).
REQ-036 Next-PC selection (REQ-021 to REQ-024) SHALL be a separate combinational sub-module named npc; the FSM, ir and pc registers SHALL stay in ifu.

Verification
REQ-037 Reset then ack=1 with rdata=32'h8C01_0004 -> imem_addr=32'h3000, then ir=32'h8C01_0004, pc=32'h3000, ir_valid=1 next cycle.
REQ-038 ir_take with no redirect at pc=32'h3000 -> next imem_addr=32'h3004.
REQ-039 ir_take, br_taken=1, br_imm=16'hFFFF at pc=32'h3008 -> imem_addr=32'h3008; br_imm=16'h0002 -> 32'h3014.
REQ-040 ir_take, jmp=1 and br_taken=1, jmp_ind=26'h0000C10, pc=32'h3010 -> imem_addr=32'h0000_3040.
REQ-041 Ack delayed 5 cycles -> imem_req and imem_addr stable throughout; ir_take pulses during REQ ignored.
REQ-042 rst asserted while waiting for ack at 32'h3004, ack in same cycle -> ir_valid=0, next request at 32'h3000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection: jump beats taken branch, which beats sequential fall-through.
module npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jmp,
  input  logic [25:0] jmp_ind,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  output logic [31:0] next_pc
);

  logic        [31:0] seq_pc;
  logic signed [31:0] br_off;
  logic        [31:0] target;

  assign seq_pc = pc + PC_INC;
  // Word offset scaled to bytes; the add wraps modulo 2^32.
  assign br_off = {{14{br_imm[15]}}, br_imm, 2'b00};

  always_comb begin
    target = seq_pc;
    if (jmp) begin
      target = {pc[31:28], jmp_ind, 2'b00};
    end else if (br_taken) begin
      target = seq_pc + $unsigned(br_off);
    end
    next_pc = {target[31:2], 2'b00};
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding request, one presented instruction, no prefetch.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        ir_valid,
  input  logic        ir_take,
  input  logic        jmp,
  input  logic [25:0] jmp_ind,
  input  logic        br_taken,
  input  logic [15:0] br_imm
);

  ifu_state_t  state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] next_pc;

  npc u_npc (
    .pc       (pc),
    .jmp      (jmp),
    .jmp_ind  (jmp_ind),
    .br_taken (br_taken),
    .br_imm   (br_imm),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ:  if (imem_ack) state_nxt = ST_HOLD;
      ST_HOLD: if (ir_take)  state_nxt = ST_REQ;
      default: state_nxt = ST_REQ;
    endcase
  end

  // Request is suppressed while reset is held so nothing leaks out mid-reset.
  always_comb begin
    imem_req  = (state == ST_REQ) && !rst;
    imem_addr = {fetch_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      ir       <= '0;
      pc       <= '0;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            pc       <= fetch_pc;
            ir_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (ir_take) begin
            ir_valid <= 1'b0;
            fetch_pc <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit: reset, sequential, branch, jump, stall, wrap and reset-abort.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        ir_valid;
  logic        ir_take;
  logic        jmp;
  logic [25:0] jmp_ind;
  logic        br_taken;
  logic [15:0] br_imm;

  int checks = 0;
  int errors = 0;

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .pc         (pc),
    .ir_valid   (ir_valid),
    .ir_take    (ir_take),
    .jmp        (jmp),
    .jmp_ind    (jmp_ind),
    .br_taken   (br_taken),
    .br_imm     (br_imm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Acknowledge the outstanding request with the given word.
  task automatic ack_word(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0;
  endtask

  // Consume the held instruction with the given redirect inputs.
  task automatic take(input logic j, input logic [25:0] ji, input logic b, input logic [15:0] bi);
    ir_take = 1'b1; jmp = j; jmp_ind = ji; br_taken = b; br_imm = bi;
    tick();
    ir_take = 1'b0; jmp = 1'b0; br_taken = 1'b0; jmp_ind = '0; br_imm = '0;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ir_take = 1'b0;
    jmp = 1'b0; jmp_ind = '0; br_taken = 1'b0; br_imm = '0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_pc", pc, 32'd0);

    rst = 1'b0; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    ack_word(32'h8C01_0004); #1;
    chk("ack_ir", ir, 32'h8C01_0004);
    chk("ack_pc", pc, 32'h0000_3000);
    chk("ack_valid", {31'd0, ir_valid}, 32'd1);
    chk("hold_noreq", {31'd0, imem_req}, 32'd0);

    // Ack during HOLD must not disturb the held instruction.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    imem_ack = 1'b0; #1;
    chk("hold_ir", ir, 32'h8C01_0004);
    chk("hold_valid", {31'd0, ir_valid}, 32'd1);

    take(1'b0, '0, 1'b0, '0);
    chk("seq_valid", {31'd0, ir_valid}, 32'd0);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("seq_addr", imem_addr, 32'h0000_3004);

    ack_word(32'h1111_0001); #1;
    take(1'b0, '0, 1'b0, '0);
    chk("seq2_addr", imem_addr, 32'h0000_3008);

    ack_word(32'h1111_0002); #1;
    chk("pc_3008", pc, 32'h0000_3008);
    take(1'b0, '0, 1'b1, 16'hFFFF);
    chk("br_back", imem_addr, 32'h0000_3008);

    ack_word(32'h1111_0003); #1;
    take(1'b0, '0, 1'b1, 16'h0002);
    chk("br_fwd", imem_addr, 32'h0000_3014);

    ack_word(32'h1111_0004); #1;
    take(1'b0, '0, 1'b1, 16'hFFFE);
    chk("br_m2", imem_addr, 32'h0000_3010);

    ack_word(32'h1111_0005); #1;
    chk("pc_3010", pc, 32'h0000_3010);
    take(1'b1, 26'h000_0C10, 1'b1, 16'h0002);
    chk("jmp_prio", imem_addr, 32'h0000_3040);

    // Slow memory with spurious ir_take pulses while waiting.
    for (int i = 0; i < 5; i++) begin
      ir_take = (i % 2 == 0);
      jmp = 1'b1; jmp_ind = 26'h3FF_FFFF;
      tick();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0000_3040);
      chk("stall_valid", {31'd0, ir_valid}, 32'd0);
    end
    ir_take = 1'b0; jmp = 1'b0; jmp_ind = '0;
    ack_word(32'h2222_0000); #1;
    chk("stall_pc", pc, 32'h0000_3040);
    chk("stall_ir", ir, 32'h2222_0000);

    take(1'b0, '0, 1'b1, 16'h8000);
    chk("br_wrap", imem_addr, 32'hFFFE_3044);

    ack_word(32'h2222_0001); #1;
    take(1'b1, 26'h3FF_FFFF, 1'b0, '0);
    chk("jmp_hinib", imem_addr, 32'hFFFF_FFFC);

    ack_word(32'h2222_0002); #1;
    take(1'b0, '0, 1'b0, '0);
    chk("seq_wrap", imem_addr, 32'h0000_0000);

    // Reset racing an ack while the request at 0x3004 is outstanding.
    rst = 1'b1; tick(); rst = 1'b0; #1;
    ack_word(32'h3333_0000); #1;
    take(1'b0, '0, 1'b0, '0);
    chk("pre_rst_addr", imem_addr, 32'h0000_3004);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h4444_0000; ir_take = 1'b1;
    tick();
    chk("rst_ack_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ack_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ack_ir", ir, 32'd0);
    rst = 1'b0; imem_ack = 1'b0; ir_take = 1'b0; #1;
    chk("reissue_req", {31'd0, imem_req}, 32'd1);
    chk("reissue_addr", imem_addr, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
